// File: rtl/led_patterns_pkg.sv
// ---------------------------------------------------------------------------
// led_patterns_pkg
// Shared constants for the seven-segment display multiplexer.
//   AN_DIG0..AN_DIG3 : active-low one-hot anode codes, one per digit
//   AN_OFF           : all anodes released (no digit lit)
//   SSEG_BLANK       : all segment cathodes released (digit dark)
//   an_code()        : digit index -> anode code
// ---------------------------------------------------------------------------
package led_patterns_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [3:0] AN_DIG0 = 4'b1110;
   localparam logic [3:0] AN_DIG1 = 4'b1101;
   localparam logic [3:0] AN_DIG2 = 4'b1011;
   localparam logic [3:0] AN_DIG3 = 4'b0111;
   localparam logic [3:0] AN_OFF  = 4'hF;

   localparam logic [7:0] SSEG_BLANK = 8'hFF;

   // Anode code for the digit currently being scanned.
   function automatic logic [3:0] an_code(input logic [1:0] sel);
      logic [3:0] code;
      code = AN_OFF;
      case (sel)
         2'd0: code = AN_DIG0;
         2'd1: code = AN_DIG1;
         2'd2: code = AN_DIG2;
         2'd3: code = AN_DIG3;
         default: code = AN_OFF;
      endcase
      return code;
   endfunction

endpackage : led_patterns_pkg

// File: rtl/led_patterns_if.sv
// ---------------------------------------------------------------------------
// led_patterns_if
// Board-pin bundle for the display wrapper.
//   btn  : per-digit enable buttons (1 = show digit)
//   sw   : raw active-low segment pattern, sw[7]=dp, sw[6:0]=g..a
//   an   : active-low digit anodes
//   sseg : active-low segment cathodes, same mapping as sw
// master = board/stimulus side, slave = display logic side.
// ---------------------------------------------------------------------------
interface led_patterns_if;

   logic [3:0] btn;
   logic [7:0] sw;
   logic [3:0] an;
   logic [7:0] sseg;

   modport master (
      output btn,
      output sw,
      input  an,
      input  sseg
   );

   modport slave (
      input  btn,
      input  sw,
      output an,
      output sseg
   );

endinterface : led_patterns_if

// File: rtl/disp_mux.sv
// ---------------------------------------------------------------------------
// disp_mux
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A free-running refresh counter selects one digit per quarter period using
// its two top bits; the selected digit shows the shared pattern when its
// enable is set and is blanked otherwise. Both outputs are registered so no
// combinational path exists from inputs to pins.
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   en_i      : per-digit enable
//   pattern_i : active-low segment pattern
//   an_o      : active-low one-hot anodes
//   sseg_o    : active-low segment cathodes
// ---------------------------------------------------------------------------
module disp_mux
   import led_patterns_pkg::*;
#(
   parameter int REFRESH_BITS = 18
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] en_i,
   input  logic [7:0] pattern_i,
   output logic [3:0] an_o,
   output logic [7:0] sseg_o
);

   localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

   logic [REFRESH_BITS-1:0] q_q;
   logic [REFRESH_BITS-1:0] q_d;
   logic [1:0]              sel;
   logic [NUM_DIGITS-1:0]   digit_on;
   logic [3:0]              an_q;
   logic [3:0]              an_d;
   logic [7:0]              sseg_q;
   logic [7:0]              sseg_d;

   // Natural binary wrap from all-ones back to zero keeps the scan gapless.
   assign q_d = q_q + CNT_ONE;
   assign sel = q_q[REFRESH_BITS-1 -: 2];

   // A digit lights its pattern only when it is the scanned digit and its
   // button is held; at most one bit of digit_on can be set.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign digit_on[gi] = (sel == 2'(gi)) && en_i[gi];
      end
   endgenerate

   always_comb begin
      an_d   = an_code(sel);
      sseg_d = SSEG_BLANK;
      if (|digit_on) begin
         sseg_d = pattern_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q    <= '0;
         an_q   <= AN_OFF;
         sseg_q <= SSEG_BLANK;
      end else begin
         q_q    <= q_d;
         an_q   <= an_d;
         sseg_q <= sseg_d;
      end
   end

   assign an_o   = an_q;
   assign sseg_o = sseg_q;

endmodule : disp_mux

// File: rtl/led_patterns_wrapper.sv
// ---------------------------------------------------------------------------
// led_patterns_wrapper
// Board-level top: buttons select which digits show the switch pattern on a
// multiplexed 4-digit seven-segment display.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   io    : pin bundle (btn, sw in; an, sseg out)
// ---------------------------------------------------------------------------
module led_patterns_wrapper
   import led_patterns_pkg::*;
#(
   parameter int REFRESH_BITS = 18
) (
   input  logic           clk,
   input  logic           reset,
   led_patterns_if.slave  io
);

   disp_mux #(
      .REFRESH_BITS (REFRESH_BITS)
   ) u_disp_mux (
      .clk       (clk),
      .reset     (reset),
      .en_i      (io.btn),
      .pattern_i (io.sw),
      .an_o      (io.an),
      .sseg_o    (io.sseg)
   );

endmodule : led_patterns_wrapper

// File: tb/tb_led_patterns_wrapper.sv
// ---------------------------------------------------------------------------
// tb_led_patterns_wrapper
// Directed and randomized stimulus for led_patterns_wrapper with a 16-clock
// scan. The reference model counts clock edges since reset release; the digit
// lit after an edge is (edges-before-it mod 16) / 4.
// ---------------------------------------------------------------------------
module tb_led_patterns_wrapper;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   m_cnt;   // edges seen since reset release (model state)

   led_patterns_if bus ();

   led_patterns_wrapper #(
      .REFRESH_BITS (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_sseg);
      total++;
      assert (bus.an === exp_an) else begin
         bad++;
         $error("FAIL %s an=%b required %b", tag, bus.an, exp_an);
      end
      total++;
      assert (bus.sseg === exp_sseg) else begin
         bad++;
         $error("FAIL %s sseg=%h required %h", tag, bus.sseg, exp_sseg);
      end
   endtask

   // One clock edge: predict from the inputs present at the edge, then check
   // 1 time unit later.
   task automatic step(input string tag);
      int         digit;
      logic [3:0] one;
      logic [3:0] exp_an;
      logic [7:0] exp_sseg;
      @(posedge clk);
      digit    = (m_cnt % 16) / 4;
      one      = 4'b0001;
      exp_an   = ~(one << digit);
      exp_sseg = bus.btn[digit] ? bus.sw : 8'hFF;
      m_cnt++;
      #1;
      check(tag, exp_an, exp_sseg);
      $display("step %-10s edge=%0d btn=%b sw=%h an=%b sseg=%h", tag, m_cnt, bus.btn, bus.sw, bus.an, bus.sseg);
   endtask

   task automatic step_until(input int phase);
      int guard;
      guard = 0;
      while ((m_cnt % 16) != phase && guard < 32) begin
         step("align");
         guard++;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_cnt = 0;

      // 1. Reset behaviour
      reset   = 1'b1;
      bus.btn = 4'b1111;
      bus.sw  = 8'hBB;
      #3;
      check("rst_async", 4'b1111, 8'hFF);
      @(posedge clk);
      #1;
      check("rst_held", 4'b1111, 8'hFF);
      reset = 1'b0;
      m_cnt = 0;
      step("rst_first");
      check("rst_first_k", 4'b1110, 8'hBB);
      for (int i = 0; i < 4; i++) step("rst_next");
      check("rst_dig1", 4'b1101, 8'hBB);

      // 2. Scan order and wrap
      for (int i = 0; i < 32; i++) step("scan");

      // 3. Single enable on digit 3
      bus.btn = 4'b1000;
      bus.sw  = 8'b10111011;
      for (int i = 0; i < 16; i++) step("single");

      // 4. Walking blank
      for (int d = 0; d < 4; d++) begin
         logic [3:0] one;
         one     = 4'b0001;
         bus.btn = ~(one << d);
         for (int i = 0; i < 16; i++) step("walk");
      end

      // 5. Mid-digit pattern change while digit 0 is lit
      bus.btn = 4'b1111;
      bus.sw  = 8'hBB;
      step_until(0);
      step("mid_a");
      bus.sw = 8'h81;
      step("mid_b");
      check("mid_k", 4'b1110, 8'h81);

      // 6. Mid-scan reset while digit 2 is lit
      step_until(9);
      check("pre_rst", 4'b1011, 8'h81);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst", 4'b1111, 8'hFF);
      @(posedge clk);
      #1;
      check("mid_rst_hold", 4'b1111, 8'hFF);
      reset = 1'b0;
      m_cnt = 0;
      step("restart");
      check("restart_k", 4'b1110, 8'h81);

      // Randomized inputs, changing mid-digit at arbitrary edges
      for (int i = 0; i < 300; i++) begin
         bus.btn = 4'($urandom_range(0, 15));
         bus.sw  = 8'($urandom);
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_led_patterns_wrapper
